// File: rtl/histogram_peak_reader.sv
// histogram_peak_reader: requests one frame's x/y histogram streams, tracks per-axis peaks and sums,
// then clears the histogram and holds the results until the next start.
module histogram_peak_reader #(
    parameter int BINS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startRead,
    output logic        readHistogram,
    output logic        clearHistogram,
    input  logic [7:0]  xHistogramOut,
    input  logic [7:0]  yHistogramOut,
    input  logic        xValid,
    input  logic        yValid,
    input  logic        histogramCleared,
    output logic [7:0]  xPeakIndex,
    output logic [7:0]  yPeakIndex,
    output logic [7:0]  xPeakValue,
    output logic [7:0]  yPeakValue,
    output logic [15:0] pixelCount,
    output logic        sumMismatch,
    output logic        overflowError,
    output logic        busy,
    output logic        resultValid
);
    localparam logic [8:0] FULL = 9'(BINS);
    localparam logic [8:0] LAST = 9'(BINS - 1);

    typedef enum logic [2:0] {IDLE, REQ, COLLECT, CLEAR, DONE} stateType;

    stateType    state, nextState;
    logic [8:0]  xCount, yCount;
    logic [15:0] xSum, ySum, xSumNext, ySumNext;
    logic        xBeat, yBeat, xOver, yOver, xDoneNext, yDoneNext, startAccept;

    assign startAccept    = state == IDLE && startRead;
    assign xBeat          = state == COLLECT && xValid && xCount != FULL;
    assign yBeat          = state == COLLECT && yValid && yCount != FULL;
    assign xOver          = state == COLLECT && xValid && xCount == FULL;
    assign yOver          = state == COLLECT && yValid && yCount == FULL;
    assign xSumNext       = xSum + (xBeat ? {8'd0, xHistogramOut} : 16'd0);
    assign ySumNext       = ySum + (yBeat ? {8'd0, yHistogramOut} : 16'd0);
    // Looking ahead at the incoming beat lets CLEAR start the cycle right after the last beat.
    assign xDoneNext      = xCount == FULL || (xBeat && xCount == LAST);
    assign yDoneNext      = yCount == FULL || (yBeat && yCount == LAST);
    assign readHistogram  = state == REQ;
    assign clearHistogram = state == CLEAR;
    assign busy           = state == REQ || state == COLLECT || state == CLEAR;
    assign pixelCount     = xSum;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = startRead ? REQ : IDLE;
            REQ:     nextState = COLLECT;
            COLLECT: nextState = (xDoneNext && yDoneNext) ? CLEAR : COLLECT;
            CLEAR:   nextState = histogramCleared ? DONE : CLEAR;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            xCount        <= '0;
            yCount        <= '0;
            xSum          <= '0;
            ySum          <= '0;
            xPeakIndex    <= '0;
            yPeakIndex    <= '0;
            xPeakValue    <= '0;
            yPeakValue    <= '0;
            sumMismatch   <= 1'b0;
            overflowError <= 1'b0;
            resultValid   <= 1'b0;
        end else begin
            state <= nextState;
            if (startAccept) begin
                xCount        <= '0;
                yCount        <= '0;
                xSum          <= '0;
                ySum          <= '0;
                xPeakIndex    <= '0;
                yPeakIndex    <= '0;
                xPeakValue    <= '0;
                yPeakValue    <= '0;
                sumMismatch   <= 1'b0;
                overflowError <= 1'b0;
                resultValid   <= 1'b0;
            end
            if (xBeat) begin
                xCount <= xCount + 9'd1;
                xSum   <= xSumNext;
                if (xHistogramOut > xPeakValue) begin
                    xPeakValue <= xHistogramOut;
                    xPeakIndex <= xCount[7:0];
                end
            end
            if (yBeat) begin
                yCount <= yCount + 9'd1;
                ySum   <= ySumNext;
                if (yHistogramOut > yPeakValue) begin
                    yPeakValue <= yHistogramOut;
                    yPeakIndex <= yCount[7:0];
                end
            end
            if (xOver || yOver)
                overflowError <= 1'b1;
            if (state == COLLECT && nextState == CLEAR)
                sumMismatch <= xSumNext != ySumNext;
            if (state == CLEAR && histogramCleared)
                resultValid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_histogram_peak_reader.sv
// tb_histogram_peak_reader: table of whole frames with hand-computed peaks/sums, plus
// overflow/disturbance and mid-frame reset sequences.
module tb_histogram_peak_reader;
    logic        clk = 1'b0, reset = 1'b1, startRead = 1'b0, xValid = 1'b0, yValid = 1'b0;
    logic        histogramCleared = 1'b0;
    logic [7:0]  xHistogramOut = '0, yHistogramOut = '0;
    logic        readHistogram, clearHistogram, sumMismatch, overflowError, busy, resultValid;
    logic [7:0]  xPeakIndex, yPeakIndex, xPeakValue, yPeakValue;
    logic [15:0] pixelCount;
    int          checks = 0, errors = 0, rdPulses = 0;

    histogram_peak_reader dut (
        .clk(clk), .reset(reset), .startRead(startRead), .readHistogram(readHistogram),
        .clearHistogram(clearHistogram), .xHistogramOut(xHistogramOut), .yHistogramOut(yHistogramOut),
        .xValid(xValid), .yValid(yValid), .histogramCleared(histogramCleared),
        .xPeakIndex(xPeakIndex), .yPeakIndex(yPeakIndex), .xPeakValue(xPeakValue),
        .yPeakValue(yPeakValue), .pixelCount(pixelCount), .sumMismatch(sumMismatch),
        .overflowError(overflowError), .busy(busy), .resultValid(resultValid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (readHistogram) rdPulses++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] binX(input int kind, input int i);
        case (kind)
            1: return (i == 37 || i == 90) ? 8'd200 : (i < 112 ? 8'd1 : 8'd0);
            2: return 8'd255;
            3: return i < 2 ? 8'd250 : 8'd0;
            4: return 8'(i);
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] binY(input int kind, input int i);
        case (kind)
            1: return i == 12 ? 8'd255 : 8'd1;
            2: return 8'd255;
            3: return i == 0 ? 8'd249 : (i == 1 ? 8'd250 : 8'd0);
            4: return 8'(255 - i);
            default: return 8'd0;
        endcase
    endfunction

    task automatic checkAllZero(input string name);
        check(name, {readHistogram, clearHistogram, xPeakIndex, yPeakIndex, xPeakValue, yPeakValue,
                     pixelCount, sumMismatch, overflowError, busy, resultValid}, 64'd0);
    endtask

    // ovf: x sends a 257th beat (value 255) before y starts; disturb: start and ack pulses mid-COLLECT
    task automatic runFrame(input int kind, input bit gaps, input int ackDelay, input bit ovf, input bit disturb);
        int xi = 0, yi = 0, cyc = 0, clrBad = 0, holdBad = 0;
        int xTot = ovf ? 257 : 256;
        rdPulses = 0;
        @(negedge clk) startRead = 1'b1;
        @(negedge clk) startRead = 1'b0;
        check("reqPulse", {readHistogram, busy, resultValid}, 3'b110);
        @(negedge clk);
        check("collectEntry", {readHistogram, clearHistogram, busy}, 3'b001);
        while (cyc < 4000 && !(xi == xTot && yi == 256)) begin
            xValid = xi < xTot && (!gaps || $urandom_range(0, 2) != 0);
            yValid = yi < 256 && (!ovf || xi >= xTot) && (!gaps || $urandom_range(0, 2) != 0);
            xHistogramOut = xValid ? (xi < 256 ? binX(kind, xi) : 8'd255) : 8'($urandom);
            yHistogramOut = yValid ? binY(kind, yi) : 8'($urandom);
            startRead = disturb && cyc == 20;
            histogramCleared = disturb && cyc == 30;
            if (xValid) xi++;
            if (yValid) yi++;
            cyc++;
            @(negedge clk);
            if (clearHistogram !== (xi >= 256 && yi >= 256)) clrBad++;
        end
        xValid = 1'b0;
        yValid = 1'b0;
        startRead = 1'b0;
        histogramCleared = 1'b0;
        check("beatBudget", cyc < 4000, 1);
        check("clearTiming", clrBad, 0);
        for (int i = 0; i < ackDelay; i++) begin
            @(negedge clk);
            if (clearHistogram !== 1'b1 || busy !== 1'b1) holdBad++;
        end
        check("clearHeld", holdBad, 0);
        histogramCleared = 1'b1;
        @(negedge clk) histogramCleared = 1'b0;
        check("ackDone", {clearHistogram, busy, resultValid}, 3'b001);
        @(negedge clk);
        check("idleHold", {clearHistogram, busy, resultValid}, 3'b001);
        check("readPulses", rdPulses, 1);
    endtask

    typedef struct {
        int         kind;
        bit         gaps;
        int         ackDelay;
        logic [7:0] xIdx, xVal, yIdx, yVal;
        logic [15:0] cnt;
        logic       mm;
    } vecType;

    vecType vecs[5];

    initial begin
        vecs[0] = '{0, 1'b0, 3, 8'd0,   8'd0,   8'd0,  8'd0,   16'd0,     1'b0};
        vecs[1] = '{1, 1'b0, 1, 8'd37,  8'd200, 8'd12, 8'd255, 16'd510,   1'b0};
        vecs[2] = '{2, 1'b1, 2, 8'd0,   8'd255, 8'd0,  8'd255, 16'd65280, 1'b0};
        vecs[3] = '{3, 1'b0, 0, 8'd0,   8'd250, 8'd1,  8'd250, 16'd500,   1'b1};
        vecs[4] = '{4, 1'b1, 5, 8'd255, 8'd255, 8'd0,  8'd255, 16'd32640, 1'b0};

        repeat (3) @(negedge clk);
        checkAllZero("resetState");
        reset = 1'b0;
        @(negedge clk);
        checkAllZero("idleAfterReset");

        for (int v = 0; v < 5; v++) begin
            runFrame(vecs[v].kind, vecs[v].gaps, vecs[v].ackDelay, 1'b0, 1'b0);
            check($sformatf("peaks[%0d]", v), {xPeakIndex, xPeakValue, yPeakIndex, yPeakValue},
                  {vecs[v].xIdx, vecs[v].xVal, vecs[v].yIdx, vecs[v].yVal});
            check($sformatf("count[%0d]", v), pixelCount, vecs[v].cnt);
            check($sformatf("flags[%0d]", v), {sumMismatch, overflowError}, {vecs[v].mm, 1'b0});
        end

        runFrame(1, 1'b0, 2, 1'b1, 1'b1);
        check("ovfPeaks", {xPeakIndex, xPeakValue, yPeakIndex, yPeakValue}, {8'd37, 8'd200, 8'd12, 8'd255});
        check("ovfCount", pixelCount, 16'd510);
        check("ovfFlags", {sumMismatch, overflowError, resultValid}, 3'b011);

        @(negedge clk) startRead = 1'b1;
        @(negedge clk) startRead = 1'b0;
        check("abortStartClears", {resultValid, overflowError, busy}, 3'b001);
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            xValid = 1'b1;
            yValid = 1'b1;
            xHistogramOut = binX(4, i);
            yHistogramOut = binY(4, i);
            @(negedge clk);
        end
        check("midCollectCount", pixelCount, 16'd4950);
        #2 reset = 1'b1;
        #1 checkAllZero("asyncResetOutputs");
        xValid = 1'b0;
        yValid = 1'b0;
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        checkAllZero("afterResetIdle");
        runFrame(3, 1'b0, 1, 1'b0, 1'b0);
        check("postResetPeaks", {xPeakIndex, xPeakValue, yPeakIndex, yPeakValue}, {8'd0, 8'd250, 8'd1, 8'd250});
        check("postResetCount", pixelCount, 16'd500);
        check("postResetFlags", {sumMismatch, overflowError, resultValid}, 3'b101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
